// File: rtl/dsconv_block_pointwise_controller.sv
// Pointwise (1x1) conv controller: issues feature/weight reads, accumulates PE results per group.
// Optional ReLU on the written result when POINTWISE_CTRL_RELU_EN is defined.
module dsconv_block_pointwise_controller #(
  parameter int NUM_PIX   = 1024,
  parameter int OUT_CH    = 32,
  parameter int IN_GROUPS = 2,
  parameter int PE_LAT    = 5,
  localparam int FA_W  = (NUM_PIX * IN_GROUPS > 1) ? $clog2(NUM_PIX * IN_GROUPS) : 1,
  localparam int WA_W  = (OUT_CH * IN_GROUPS > 1) ? $clog2(OUT_CH * IN_GROUPS) : 1,
  localparam int OA_W  = (NUM_PIX * OUT_CH > 1) ? $clog2(NUM_PIX * OUT_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic                   feat_rd_en,
  output logic [FA_W-1:0]        feat_rd_addr,
  output logic [WA_W-1:0]        wgt_rd_addr,
  output logic                   pe_start,
  input  logic signed [17:0]     pe_pixel,
  output logic                   out_wr_en,
  output logic [OA_W-1:0]        out_wr_addr,
  output logic signed [17:0]     out_wr_data
);

  localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int OCH_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int GRP_W = (IN_GROUPS > 1) ? $clog2(IN_GROUPS) : 1;
  localparam int ACC_W = 18 + $clog2(IN_GROUPS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  typedef struct packed {
    logic            valid;
    logic            first;
    logic            last;
    logic [OA_W-1:0] addr;
  } tag_t;

  state_t state;
  logic [PIX_W-1:0] pix;
  logic [OCH_W-1:0] och;
  logic [GRP_W-1:0] grp;
  tag_t iss_tag;
  tag_t pipe [PE_LAT+1];
  tag_t tag_out;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] pe_ext;
  logic [ACC_W-18:0] top;
  logic signed [17:0] sat;
  logic signed [17:0] res;
  logic grp_last, och_last, pix_last, last_issue;
  logic issue_ok, pipe_busy;
  logic [FA_W-1:0] feat_a;
  logic [WA_W-1:0] wgt_a;
  logic [OA_W-1:0] out_a;

  always_comb begin
    grp_last   = (grp == GRP_W'(IN_GROUPS - 1));
    och_last   = (och == OCH_W'(OUT_CH - 1));
    pix_last   = (pix == PIX_W'(NUM_PIX - 1));
    last_issue = grp_last && och_last && pix_last;
    issue_ok   = ((state == IDLE && start) || state == RUN) && !stall;
    feat_a = FA_W'(int'(pix) * IN_GROUPS + int'(grp));
    wgt_a  = WA_W'(int'(och) * IN_GROUPS + int'(grp));
    out_a  = OA_W'(int'(och) * NUM_PIX + int'(pix));
  end

  always_comb begin
    pipe_busy = iss_tag.valid;
    for (int i = 0; i <= PE_LAT; i++)
      pipe_busy = pipe_busy | pipe[i].valid;
  end

  // Accumulate the exiting tag's PE result, then clamp to 18 bits
  always_comb begin
    tag_out = pipe[PE_LAT];
    pe_ext  = {{(ACC_W-18){pe_pixel[17]}}, pe_pixel};
    sum     = tag_out.first ? pe_ext : acc + pe_ext;
    top     = sum[ACC_W-1:17];
    if (&top || ~|top)
      sat = sum[17:0];
    else
      sat = sum[ACC_W-1] ? 18'sh20000 : 18'sh1FFFF;
`ifdef POINTWISE_CTRL_RELU_EN
    res = sat[17] ? 18'sd0 : sat;
`else
    res = sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pix          <= '0;
      och          <= '0;
      grp          <= '0;
      iss_tag      <= '0;
      for (int i = 0; i <= PE_LAT; i++)
        pipe[i] <= '0;
      acc          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      feat_rd_en   <= 1'b0;
      feat_rd_addr <= '0;
      wgt_rd_addr  <= '0;
      pe_start     <= 1'b0;
      out_wr_en    <= 1'b0;
      out_wr_addr  <= '0;
      out_wr_data  <= '0;
    end else begin
      done     <= 1'b0;
      pe_start <= feat_rd_en;
      pipe[0]  <= iss_tag;
      for (int i = 1; i <= PE_LAT; i++)
        pipe[i] <= pipe[i-1];

      out_wr_en <= 1'b0;
      if (tag_out.valid) begin
        acc <= sum;
        if (tag_out.last) begin
          out_wr_en   <= 1'b1;
          out_wr_addr <= tag_out.addr;
          out_wr_data <= res;
        end
      end

      if (issue_ok) begin
        feat_rd_en    <= 1'b1;
        feat_rd_addr  <= feat_a;
        wgt_rd_addr   <= wgt_a;
        iss_tag.valid <= 1'b1;
        iss_tag.first <= (grp == '0);
        iss_tag.last  <= grp_last;
        iss_tag.addr  <= out_a;
        if (grp_last) begin
          grp <= '0;
          if (och_last) begin
            och <= '0;
            pix <= pix_last ? '0 : pix + 1'b1;
          end else begin
            och <= och + 1'b1;
          end
        end else begin
          grp <= grp + 1'b1;
        end
      end else begin
        feat_rd_en    <= 1'b0;
        iss_tag.valid <= 1'b0;
      end

      unique case (state)
        IDLE: if (start) begin
          busy  <= 1'b1;
          state <= (issue_ok && last_issue) ? DRAIN : RUN;
        end
        RUN: if (issue_ok && last_issue) state <= DRAIN;
        DRAIN: if (!pipe_busy) begin
          state <= FIN;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsconv_block_pointwise_controller.sv
// Directed bench for the pointwise controller: two instances (IN_GROUPS=2 and 1).
// Table-driven layer runs plus hand-written reset/abort sequence.
module tb_dsconv_block_pointwise_controller;

  localparam int NP = 4;
  localparam int OC = 2;
  localparam int PL = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stall, start2, stall2;
  int mode;
  int n_tests = 0;
  int n_fail  = 0;

  logic busy1, done1, f_en1, pe_start1, o_en1;
  logic [2:0] f_addr1;
  logic [1:0] w_addr1;
  logic [2:0] o_addr1;
  logic signed [17:0] pe1, o_data1;

  logic busy2, done2, f_en2, pe_start2, o_en2;
  logic [1:0] f_addr2;
  logic [0:0] w_addr2;
  logic [2:0] o_addr2;
  logic signed [17:0] pe2, o_data2;

  dsconv_block_pointwise_controller #(
    .NUM_PIX(NP), .OUT_CH(OC), .IN_GROUPS(2), .PE_LAT(PL)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy1), .done(done1), .feat_rd_en(f_en1),
    .feat_rd_addr(f_addr1), .wgt_rd_addr(w_addr1),
    .pe_start(pe_start1), .pe_pixel(pe1),
    .out_wr_en(o_en1), .out_wr_addr(o_addr1), .out_wr_data(o_data1)
  );

  dsconv_block_pointwise_controller #(
    .NUM_PIX(NP), .OUT_CH(OC), .IN_GROUPS(1), .PE_LAT(PL)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stall(stall2),
    .busy(busy2), .done(done2), .feat_rd_en(f_en2),
    .feat_rd_addr(f_addr2), .wgt_rd_addr(w_addr2),
    .pe_start(pe_start2), .pe_pixel(pe2),
    .out_wr_en(o_en2), .out_wr_addr(o_addr2), .out_wr_data(o_data2)
  );

  function automatic logic signed [17:0] pe_f(input int md, input int fa, input int wa);
    case (md)
      1: return (wa % 2 == 0) ? 18'sd100 : 18'sd200;
      2: return 18'sh1FFFF;
      3: return 18'sh20000;
      default: return 18'(fa * 1000 + wa * 10 + 7);
    endcase
  endfunction

  // PE stand-in: result appears PE_LAT cycles after pe_start
  logic signed [17:0] pv1 [0:PL];
  logic signed [17:0] pv2 [0:PL];
  always @(posedge clk) begin
    pv1[0] <= pe_f(mode, int'(f_addr1), int'(w_addr1));
    pv2[0] <= pe_f(mode, int'(f_addr2), int'(w_addr2));
    for (int k = 1; k <= PL; k++) begin
      pv1[k] <= pv1[k-1];
      pv2[k] <= pv2[k-1];
    end
  end
  assign pe1 = pv1[PL];
  assign pe2 = pv2[PL];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_data(input int sel, input int md, input int p, input int o);
    if (sel == 1) return 1000 * p + 10 * o + 7;
    case (md)
      1: return 300;
      2: return 131071;
`ifdef POINTWISE_CTRL_RELU_EN
      3: return 0;
`else
      3: return -131072;
`endif
      default: return 4000 * p + 40 * o + 1024;
    endcase
  endfunction

  typedef struct {
    int sel;
    int md;
    int sfrom;
    int sto;
    int rcyc;
    int exp_done;
    int exp_last;
  } vec_t;

  vec_t vecs [7];

  task automatic run_case(input vec_t v);
    int iss_c[$];
    int iss_f[$];
    int iss_w[$];
    int wr_a[$];
    int wr_d[$];
    int done_c, done_n, bz1, bz_end, bad, ig, ni, ncyc;
    logic fe, we, dn, bz;
    int fa, wa, oa, od;
    done_c = -1;
    done_n = 0;
    bz1 = -1;
    bz_end = -1;
    ig = (v.sel == 1) ? 1 : 2;
    ni = NP * OC * ig;
    ncyc = v.exp_done + 5;
    mode = v.md;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (v.sel == 0) begin
        start = (c == 0) || (c == v.rcyc);
        stall = (c >= v.sfrom) && (c <= v.sto);
        fe = f_en1; fa = int'(f_addr1); wa = int'(w_addr1);
        we = o_en1; oa = int'(o_addr1); od = int'(o_data1);
        dn = done1; bz = busy1;
      end else begin
        start2 = (c == 0);
        fe = f_en2; fa = int'(f_addr2); wa = int'(w_addr2);
        we = o_en2; oa = int'(o_addr2); od = int'(o_data2);
        dn = done2; bz = busy2;
      end
      if (fe) begin
        iss_c.push_back(c);
        iss_f.push_back(fa);
        iss_w.push_back(wa);
      end
      if (we) begin
        wr_a.push_back(oa);
        wr_d.push_back(od);
      end
      if (dn) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (c == 1) bz1 = int'(bz);
      if (c == ncyc - 1) bz_end = int'(bz);
    end
    start = 1'b0;
    start2 = 1'b0;
    stall = 1'b0;

    check("issue_count", iss_c.size(), ni);
    check("first_issue", (iss_c.size() > 0) ? iss_c[0] : -1, 1);
    check("last_issue", (iss_c.size() > 0) ? iss_c[iss_c.size()-1] : -1, v.exp_last);
    bad = 0;
    for (int k = 0; k < iss_c.size(); k++) begin
      int g, o, p;
      g = k % ig;
      o = (k / ig) % OC;
      p = k / (ig * OC);
      if (iss_f[k] != p * ig + g) bad++;
      if (iss_w[k] != o * ig + g) bad++;
    end
    check("rd_addr_seq", bad, 0);
    check("write_count", wr_a.size(), NP * OC);
    bad = 0;
    for (int k = 0; k < wr_a.size(); k++) begin
      int o, p;
      o = k % OC;
      p = k / OC;
      if (wr_a[k] != o * NP + p) bad++;
      check("wr_data", wr_d[k], exp_data(v.sel, v.md, p, o));
    end
    check("wr_addr_seq", bad, 0);
    check("done_cycle", done_c, v.exp_done);
    check("done_pulses", done_n, 1);
    check("busy_c1", bz1, 1);
    check("busy_idle", bz_end, 0);
  endtask

  initial begin
    int nwr, nd;
    vecs[0] = '{0, 0, 99, 0, -1, 24, 16};
    vecs[1] = '{0, 1, 99, 0, -1, 24, 16};
    vecs[2] = '{0, 2, 99, 0, -1, 24, 16};
    vecs[3] = '{0, 3, 99, 0, -1, 24, 16};
    vecs[4] = '{0, 0, 3, 6, -1, 28, 20};
    vecs[5] = '{0, 0, 99, 0, 5, 24, 16};
    vecs[6] = '{1, 0, 99, 0, -1, 16, 8};

    mode = 0;
    rst = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    start2 = 1'b0;
    stall2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", int'({busy1, done1, f_en1, pe_start1, o_en1}), 0);
    check("reset_addrs", int'({f_addr1, w_addr1, o_addr1}), 0);
    check("reset_data", int'(o_data1), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_case(vecs[i]);

    // Abort a layer with reset after the first write
    nwr = 0;
    mode = 0;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      start = (c == 0);
      rst = (c == 10);
      if (c <= 10 && o_en1) nwr++;
      if (c == 11) begin
        check("abort_ctrl", int'({busy1, done1, f_en1, pe_start1, o_en1}), 0);
        check("abort_addrs", int'({f_addr1, w_addr1, o_addr1}), 0);
        check("abort_data", int'(o_data1), 0);
      end
    end
    check("pre_abort_writes", nwr, 1);
    nwr = 0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (o_en1) nwr++;
      if (done1) nd++;
    end
    check("post_abort_writes", nwr, 0);
    check("post_abort_done", nd, 0);

    run_case(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
